multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: Moore datapath controls with Mealy IRWrite/PCEn/IllegalOp.
// Optional memory wait states (MEM_WAIT) and extended opcode decode (EXT_ISA).
module multicycle_ctrl #(
   parameter int MEM_WAIT = 1,
   parameter int EXT_ISA  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       IorD,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       MemReq,
   output logic       PCEn,
   output logic       IllegalOp,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RTEND  = 4'd7,
      S_BEQ    = 4'd8,
      S_BNE    = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam bit WAIT_EN = (MEM_WAIT != 0);
   localparam bit EXT_EN  = (EXT_ISA != 0);

   state_t state, state_nxt;

   logic rdy;
   logic pc_write, pc_write_cond, pc_write_cond_n;
   logic ir_write, reg_write, mem_write, mem_req, illegal_op;

   assign rdy = WAIT_EN ? MemReady : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt       = S_FETCH;
      IorD            = 1'b0;
      mem_write       = 1'b0;
      MemtoReg        = 1'b0;
      ir_write        = 1'b0;
      RegDst          = 1'b0;
      reg_write       = 1'b0;
      ALUSrcA         = 1'b0;
      ALUSrcB         = 2'b00;
      ALUOp           = 2'b00;
      PCSrc           = 2'b00;
      mem_req         = 1'b0;
      pc_write        = 1'b0;
      pc_write_cond   = 1'b0;
      pc_write_cond_n = 1'b0;
      illegal_op      = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = 2'b01;
            ir_write  = rdy;
            pc_write  = rdy;
            state_nxt = rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            if (Op == OP_LW || Op == OP_SW)  state_nxt = S_MEMADR;
            else if (Op == OP_RTYP)          state_nxt = S_EXEC;
            else if (Op == OP_BEQ)           state_nxt = S_BEQ;
            else if (EXT_EN && Op == OP_BNE)  state_nxt = S_BNE;
            else if (EXT_EN && Op == OP_ADDI) state_nxt = S_ADDIEX;
            else if (EXT_EN && Op == OP_J)    state_nxt = S_JUMP;
            else begin
               state_nxt  = S_FETCH;
               illegal_op = 1'b1;
            end
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (Op == OP_LW)      state_nxt = S_MEMRD;
            else if (Op == OP_SW) state_nxt = S_MEMWR;
            else                  state_nxt = S_FETCH;
         end
         S_MEMRD: begin
            IorD      = 1'b1;
            mem_req   = 1'b1;
            state_nxt = rdy ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            MemtoReg  = 1'b1;
         end
         S_MEMWR: begin
            IorD      = 1'b1;
            mem_req   = 1'b1;
            mem_write = 1'b1;
            state_nxt = rdy ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            ALUSrcA   = 1'b1;
            ALUOp     = 2'b10;
            state_nxt = S_RTEND;
         end
         S_RTEND: begin
            RegDst    = 1'b1;
            reg_write = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA       = 1'b1;
            ALUOp         = 2'b01;
            PCSrc         = 2'b01;
            pc_write_cond = 1'b1;
         end
         S_BNE: begin
            ALUSrcA         = 1'b1;
            ALUOp           = 2'b01;
            PCSrc           = 2'b01;
            pc_write_cond_n = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            state_nxt = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JUMP: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   // Side-effecting strobes are suppressed while reset is held, whatever the state.
   assign PCEn      = ~reset & (pc_write | (pc_write_cond & Zero) | (pc_write_cond_n & ~Zero));
   assign IRWrite   = ~reset & ir_write;
   assign RegWrite  = ~reset & reg_write;
   assign MemWrite  = ~reset & mem_write;
   assign MemReq    = ~reset & mem_req;
   assign IllegalOp = ~reset & illegal_op;
   assign State     = state;

endmodule
